// File: rtl/batch_norm_mc_pkg.sv
// Shared types and defaults for the multi-channel batch-normalisation engine.
package batch_norm_mc_pkg;

    localparam int DEF_ROWS        = 4;
    localparam int DEF_COLS        = 4;
    localparam int DEF_CHANNELS    = 2;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_BYTE_OFFSET = 4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SUM,
        S_MEAN,
        S_VAR,
        S_SQRT,
        S_NORM_RD,
        S_NORM_WR,
        S_NEXT_CH,
        S_DONE
    } bn_state_e;

endpackage

// File: rtl/batch_norm_mc_isqrt.sv
// isqrt_seq: sequential restoring integer square root, one result bit per cycle.
module isqrt_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [63:0] radicand_i,
    output logic [31:0] root_o,
    output logic        done_o
);

    logic [63:0] x_q;
    logic [37:0] rem_q;
    logic [31:0] root_q;
    logic [4:0]  cnt_q;
    logic        busy_q;
    logic        done_q;

    logic [39:0] rem_sh;
    logic [39:0] trial;
    logic [39:0] rem_diff;
    logic        rem_ge;
    logic        rem_unused;

    // Bring down the next two radicand bits and try appending a 1 to the root.
    assign rem_sh     = {rem_q, x_q[63:62]};
    assign trial      = {6'd0, root_q, 2'b01};
    assign rem_diff   = rem_sh - trial;
    assign rem_ge     = (rem_sh >= trial);
    assign rem_unused = ^{rem_sh[39:38], rem_diff[39:38]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q    <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                x_q    <= radicand_i;
                rem_q  <= '0;
                root_q <= '0;
                cnt_q  <= '0;
                busy_q <= 1'b1;
            end else if (busy_q) begin
                x_q    <= {x_q[61:0], 2'b00};
                rem_q  <= rem_ge ? rem_diff[37:0] : rem_sh[37:0];
                root_q <= {root_q[30:0], rem_ge};
                cnt_q  <= cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign root_o = root_q;
    assign done_o = done_q;

endmodule

// File: rtl/batch_norm_mc.sv
// Per-channel batch normalisation over a BRAM-resident feature map: mean, variance,
// integer std, then in-place (x-mean)/std. Define BN_RELU_EN to clamp negative results to 0.
module batch_norm_mc
    import batch_norm_mc_pkg::*;
#(
    parameter int ROWS        = DEF_ROWS,
    parameter int COLS        = DEF_COLS,
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int BYTE_OFFSET = DEF_BYTE_OFFSET
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ps_control,
    output logic [31:0] pl_status,
    output logic [31:0] iFM_addr,
    input  logic [31:0] iFM_rddata,
    output logic [31:0] iFM_wrdata,
    output logic [3:0]  iFM_we,
    output bn_state_e   dbg_state_o
);

    localparam int                 N        = ROWS * COLS;
    localparam int                 CNT_W    = $clog2(N + 1);
    localparam logic [31:0]        STRIDE   = 32'(BYTE_OFFSET);
    localparam logic [31:0]        CH_BYTES = 32'(N * BYTE_OFFSET);
    localparam logic signed [63:0] N_S      = 64'(N);
    localparam logic [63:0]        N_U      = 64'(N);
    localparam logic signed [63:0] Y_MAX    = (64'sd1 <<< (DATA_W - 1)) - 64'sd1;
    localparam logic signed [63:0] Y_MIN    = -(64'sd1 <<< (DATA_W - 1));

    bn_state_e          state_q;
    logic [7:0]         ch_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        base_q;
    logic [31:0]        addr_q;
    logic signed [63:0] sum_q;
    logic [63:0]        acc_q;
    logic signed [63:0] mean_q;
    logic [63:0]        var_q;
    logic [31:0]        std_q;
    logic               sq_start_q;

    logic                     sq_done;
    logic [31:0]              sq_root;
    logic signed [DATA_W-1:0] x_w;
    logic signed [63:0]       x64;
    logic signed [63:0]       diff;
    logic [63:0]              sq;
    logic signed [63:0]       quot;
    logic signed [63:0]       y_sat;
    logic signed [63:0]       y_fin;
    logic signed [DATA_W-1:0] y_n;
    logic                     last_elem;
    logic                     cnt_full;
    logic [31:0]              next_addr;
    logic                     unused_bits;

    assign x_w       = iFM_rddata[DATA_W-1:0];
    assign x64       = 64'(x_w);
    assign diff      = x64 - mean_q;
    assign sq        = 64'(diff * diff);
    assign last_elem = (cnt_q == CNT_W'(N - 1));
    assign cnt_full  = (cnt_q == CNT_W'(N));
    // Streaming passes fold back to the channel base so the pass that follows starts aligned.
    assign next_addr = last_elem ? base_q : addr_q + STRIDE;

    assign quot  = diff / $signed({32'd0, std_q});
    assign y_sat = (quot > Y_MAX) ? Y_MAX : ((quot < Y_MIN) ? Y_MIN : quot);
`ifdef BN_RELU_EN
    assign y_fin = y_sat[63] ? 64'sd0 : y_sat;
`else
    assign y_fin = y_sat;
`endif
    assign y_n = y_fin[DATA_W-1:0];

    assign unused_bits = ^{ps_control[31:1], iFM_rddata, y_fin};

    isqrt_seq u_isqrt (
        .clk       (clk),
        .rst       (reset),
        .start_i   (sq_start_q),
        .radicand_i(var_q),
        .root_o    (sq_root),
        .done_o    (sq_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ch_q       <= '0;
            cnt_q      <= '0;
            base_q     <= '0;
            addr_q     <= '0;
            sum_q      <= '0;
            acc_q      <= '0;
            mean_q     <= '0;
            var_q      <= '0;
            std_q      <= '0;
            sq_start_q <= 1'b0;
        end else begin
            sq_start_q <= 1'b0;
            case (state_q)
                S_IDLE: if (ps_control[0]) begin
                    ch_q    <= '0;
                    base_q  <= '0;
                    addr_q  <= '0;
                    cnt_q   <= '0;
                    sum_q   <= '0;
                    acc_q   <= '0;
                    state_q <= S_SUM;
                end
                S_SUM: begin
                    if (cnt_q != '0) sum_q <= sum_q + x64;
                    if (cnt_full) begin
                        cnt_q   <= '0;
                        state_q <= S_MEAN;
                    end else begin
                        cnt_q  <= cnt_q + 1'b1;
                        addr_q <= next_addr;
                    end
                end
                S_MEAN: begin
                    mean_q  <= sum_q / N_S;
                    state_q <= S_VAR;
                end
                S_VAR: begin
                    if (cnt_q != '0) acc_q <= acc_q + sq;
                    if (cnt_full) begin
                        var_q      <= (acc_q + sq) / N_U;
                        sq_start_q <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= S_SQRT;
                    end else begin
                        cnt_q  <= cnt_q + 1'b1;
                        addr_q <= next_addr;
                    end
                end
                S_SQRT: if (sq_done) begin
                    std_q   <= (sq_root == '0) ? 32'd1 : sq_root;
                    state_q <= S_NORM_RD;
                end
                S_NORM_RD: state_q <= S_NORM_WR;
                S_NORM_WR: begin
                    if (last_elem) begin
                        state_q <= S_NEXT_CH;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                        addr_q  <= addr_q + STRIDE;
                        state_q <= S_NORM_RD;
                    end
                end
                S_NEXT_CH: begin
                    sum_q <= '0;
                    acc_q <= '0;
                    cnt_q <= '0;
                    if (ch_q == 8'(CHANNELS - 1)) begin
                        state_q <= S_DONE;
                    end else begin
                        ch_q    <= ch_q + 8'd1;
                        base_q  <= base_q + CH_BYTES;
                        addr_q  <= base_q + CH_BYTES;
                        state_q <= S_SUM;
                    end
                end
                S_DONE: if (!ps_control[0]) begin
                    ch_q    <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Write strobe and data decode straight from state so a reset kills them in the same cycle.
    assign iFM_addr    = addr_q;
    assign iFM_we      = (state_q == S_NORM_WR) ? 4'hF : 4'h0;
    assign iFM_wrdata  = (state_q == S_NORM_WR) ? 32'(y_n) : 32'd0;
    assign pl_status   = {16'd0, ch_q, 6'd0,
                          (state_q != S_IDLE) && (state_q != S_DONE),
                          (state_q == S_DONE)};
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_batch_norm_mc.sv
// Directed bench for batch_norm_mc with a read-first BRAM model (one-cycle read latency).
module tb_batch_norm_mc;
  import batch_norm_mc_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] ps_control;
  logic [31:0] pl_status;
  logic [31:0] iFM_addr;
  logic [31:0] iFM_rddata;
  logic [31:0] iFM_wrdata;
  logic [3:0]  iFM_we;
  bn_state_e   dbg_state;

  logic [31:0] mem [0:31];
  int          wr_cnt;
  int          n_cmp;
  int          n_err;

  // expected results for ramps x=i, x=-2i, x=-i (before optional clamp)
  int ramp_exp [16] = '{-1, -1, -1, -1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 2};
  int neg2_exp [16] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, -1, -1, -1, -1};
  int negr_exp [16] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, -1, -1, -1, -1, -2};
  int zero_exp [16] = '{default: 0};

  batch_norm_mc dut (
    .clk        (clk),
    .reset      (reset),
    .ps_control (ps_control),
    .pl_status  (pl_status),
    .iFM_addr   (iFM_addr),
    .iFM_rddata (iFM_rddata),
    .iFM_wrdata (iFM_wrdata),
    .iFM_we     (iFM_we),
    .dbg_state_o(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    iFM_rddata <= mem[iFM_addr[6:2]];
    if (iFM_we == 4'hF) begin
      mem[iFM_addr[6:2]] <= iFM_wrdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int clamp_exp(input int v);
`ifdef BN_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  always @(negedge clk) begin
    if (iFM_we != 4'h0) begin
      check("we_value", {28'd0, iFM_we}, 32'h0000_000F);
      check("we_state", 32'(dbg_state), 32'(S_NORM_WR));
      check("wr_range", 32'(iFM_addr < 32'd128), 32'd1);
      check("wr_no_x", 32'($isunknown(iFM_wrdata)), 32'd0);
    end
  end

  task automatic fill_ramp(input int c, input int scale);
    for (int i = 0; i < 16; i++) mem[c * 16 + i] = 32'(scale * i);
  endtask

  task automatic fill_const(input int c, input int v);
    for (int i = 0; i < 16; i++) mem[c * 16 + i] = 32'(v);
  endtask

  task automatic check_channel(input int c, input int exp_v [16]);
    for (int i = 0; i < 16; i++)
      check($sformatf("ch%0d_word%0d", c, i), mem[c * 16 + i], 32'(clamp_exp(exp_v[i])));
  endtask

  task automatic run_job(input bit hold);
    int cyc;
    bit saw_ch1;
    saw_ch1 = 1'b0;
    wr_cnt = 0;
    @(negedge clk);
    ps_control = 32'h1;
    cyc = 0;
    while (!pl_status[0] && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (pl_status[15:8] == 8'd1 && pl_status[1]) saw_ch1 = 1'b1;
    end
    check("run_done", {31'd0, pl_status[0]}, 32'd1);
    check("done_status", pl_status, 32'h0000_0101);
    check("ch1_busy_seen", 32'(saw_ch1), 32'd1);
    check("write_count", 32'(wr_cnt), 32'd32);
    if (hold) begin
      repeat (10) @(negedge clk);
      check("hold_status", pl_status, 32'h0000_0101);
      check("hold_state", 32'(dbg_state), 32'(S_DONE));
      check("hold_no_rerun", 32'(wr_cnt), 32'd32);
    end
    ps_control = 32'h0;
    @(negedge clk);
    check("back_idle", 32'(dbg_state), 32'(S_IDLE));
    check("idle_status", pl_status, 32'h0);
  endtask

  initial begin
    int cyc;
    int snap;
    n_cmp = 0;
    n_err = 0;
    wr_cnt = 0;
    reset = 1'b1;
    ps_control = 32'h0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_status", pl_status, 32'h0);
    check("rst_addr", iFM_addr, 32'h0);
    check("rst_we", {28'd0, iFM_we}, 32'h0);
    check("rst_wrdata", iFM_wrdata, 32'h0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_no_start", 32'(dbg_state), 32'(S_IDLE));

    // ch0 constant 10, ch1 ramp 0..15
    fill_const(0, 10);
    fill_ramp(1, 1);
    run_job(1'b0);
    check_channel(0, zero_exp);
    check_channel(1, ramp_exp);

    // negative data; ch1 mean -7.5 must truncate to -7
    fill_ramp(0, -2);
    fill_ramp(1, -1);
    run_job(1'b0);
    check_channel(0, neg2_exp);
    check_channel(1, negr_exp);

    // zero variance on both channels, start held through DONE
    fill_const(0, 5);
    fill_const(1, 5);
    run_job(1'b1);
    check_channel(0, zero_exp);
    check_channel(1, zero_exp);

    // abort during ch0 normalisation, then restart from channel 0
    fill_const(0, 10);
    fill_ramp(1, 1);
    @(negedge clk);
    ps_control = 32'h1;
    cyc = 0;
    while (dbg_state != S_NORM_WR && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_norm_wr", 32'(dbg_state), 32'(S_NORM_WR));
    check("norm_ch0", {24'd0, pl_status[15:8]}, 32'd0);
    check("we_before_rst", {28'd0, iFM_we}, 32'h0000_000F);
    reset = 1'b1;
    ps_control = 32'h0;
    #1;
    check("abort_we", {28'd0, iFM_we}, 32'h0);
    check("abort_state", 32'(dbg_state), 32'(S_IDLE));
    check("abort_status", pl_status, 32'h0);
    snap = wr_cnt;
    repeat (3) @(negedge clk);
    check("abort_no_write", 32'(wr_cnt), 32'(snap));
    reset = 1'b0;
    fill_const(0, 10);
    fill_ramp(1, 1);
    run_job(1'b0);
    check_channel(0, zero_exp);
    check_channel(1, ramp_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
